// File: rtl/game_control_pkg.sv
// game_control_pkg: state encodings and default frame divider shared by game_control.
// PAUSED exists only when PAUSE_EN is defined.
package game_control_pkg;
   localparam int FRAME_DIV_DEFAULT = 833333;
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_FRAME = 3'd1,
      SHIP_UPD   = 3'd2,
      GRID_UPD   = 3'd3,
      CHECK      = 3'd4,
      GAMEOVER   = 3'd5
`ifdef PAUSE_EN
      , PAUSED   = 3'd6
`endif
   } state_e;
endpackage

// File: rtl/game_control_frame_tick_gen.sv
// frame_tick_gen: free-running frame counter 0..FRAME_DIV-1, tick on the last count while running.
module frame_tick_gen
   import game_control_pkg::*;
#(
   parameter int FRAME_DIV = FRAME_DIV_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic frame_tick
);
   localparam int W = $clog2(FRAME_DIV);
   localparam logic [W-1:0] LAST = W'(FRAME_DIV - 1);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = clear ? '0 : !run ? cnt_q : cnt_q == LAST ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign frame_tick = run && cnt_q == LAST;
endmodule

// File: rtl/game_control.sv
// game_control: per-frame sequencer for ship/grid updates, health/score events and game over.
// Defining PAUSE_EN adds a pause button and a PAUSED state that freezes the frame counter.
module game_control
   import game_control_pkg::*;
#(
   parameter int FRAME_DIV = FRAME_DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       key_right,
   input  logic       key_left,
   input  logic       key_shoot,
`ifdef PAUSE_EN
   input  logic       pause,
`endif
   input  logic       hit,
   input  logic       kill,
   input  logic [3:0] ship_health,
   output logic       right,
   output logic       left,
   output logic       shoot,
   output logic       shipUpdateEn,
   output logic       gridUpdateEn,
   output logic       health_update,
   output logic       current_score_update,
   output logic       gameover_signal,
   output logic [2:0] state_o
);
`ifdef PAUSE_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   // raw bits: 0 left, 1 right, 2 shoot, 3 start, 4 pause; only bits 2+ are edge detected
   logic [NB-1:0] raw, sync1_q, sync1_d, sync2_q, sync2_d;
   logic [NB-3:0] sync3_q, sync3_d, edges;
   state_e state_q, state_d;
   logic shoot_q, shoot_d, gameover_q, gameover_d;
   logic run, clear, frame_tick, active, dead, ship_upd, hold;
`ifdef PAUSE_EN
   assign raw  = {pause, start, key_shoot, key_right, key_left};
   assign hold = state_q == PAUSED;
   assign run  = active && state_d != PAUSED;
`else
   assign raw  = {start, key_shoot, key_right, key_left};
   assign hold = 1'b0;
   assign run  = active;
`endif
   assign edges    = sync2_q[NB-1:2] & ~sync3_q;
   assign active   = state_q inside {WAIT_FRAME, SHIP_UPD, GRID_UPD, CHECK};
   assign clear    = state_q == IDLE && edges[1];
   assign ship_upd = state_q == SHIP_UPD;
   assign dead     = ship_health == 4'd0 || (hit && ship_health == 4'd1);
   frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_frame (
      .clk(clk),
      .reset(reset),
      .run(run),
      .clear(clear),
      .frame_tick(frame_tick)
   );
   always_comb begin
      sync1_d    = raw;
      sync2_d    = sync1_q;
      sync3_d    = sync2_q[NB-1:2];
      shoot_d    = hold ? shoot_q : ship_upd ? edges[0] : shoot_q | edges[0];
      state_d    = state_q;
      case (state_q)
         IDLE:       if (edges[1]) state_d = WAIT_FRAME;
         WAIT_FRAME: if (frame_tick) state_d = SHIP_UPD;
`ifdef PAUSE_EN
                     else if (edges[2]) state_d = PAUSED;
         PAUSED:     if (edges[2]) state_d = WAIT_FRAME;
`endif
         SHIP_UPD:   state_d = GRID_UPD;
         GRID_UPD:   state_d = CHECK;
         CHECK:      state_d = dead ? GAMEOVER : WAIT_FRAME;
         GAMEOVER:   if (edges[1]) state_d = IDLE;
         default:    state_d = IDLE;
      endcase
      gameover_d = state_q == CHECK && dead;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         sync3_q    <= '0;
         state_q    <= IDLE;
         shoot_q    <= 1'b0;
         gameover_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         sync3_q    <= sync3_d;
         state_q    <= state_d;
         shoot_q    <= shoot_d;
         gameover_q <= gameover_d;
      end
   assign state_o              = state_q;
   assign shipUpdateEn         = ship_upd;
   assign gridUpdateEn         = state_q == GRID_UPD;
   assign right                = ship_upd && sync2_q[1] && !sync2_q[0];
   assign left                 = ship_upd && sync2_q[0] && !sync2_q[1];
   assign shoot                = ship_upd && shoot_q;
   assign health_update        = state_q == CHECK && hit;
   assign current_score_update = state_q == CHECK && kill;
   assign gameover_signal      = gameover_q;
endmodule
